// File: rtl/store_align_unit.sv
// -----------------------------------------------------------------------------
// store_align_unit
//
// Store formatter between the execute stage and data memory. It accepts one
// store request per handshake, places the low S bytes of the source register
// into the correct byte lanes and raises the matching write strobes. It then
// drives the result on a registered valid/ready write port.
//
// Configuration macro: STORE_SPLIT_EN
//   defined   - a store that crosses a memory-word boundary is issued as two
//               beats (BEAT0 at the base word, BEAT1 at the next word).
//   undefined - a crossing store is consumed without any beat and pulses
//               misalign_err. BEAT1 is never entered.
//
// Parameters
//   XLEN   : data bus width, 32 or 64 (NB = XLEN/8 byte lanes)
//   ADDR_W : byte address width
//
// Ports
//   clk, rst_n        : clock, asynchronous active-low reset
//   req_valid/ready   : store request handshake (ready only in IDLE)
//   req_addr          : byte address of the store
//   req_data          : register value, low S bytes are stored
//   req_funct3        : 000 SB, 001 SH, 010 SW, 011 SD (XLEN=64 only)
//   mem_valid/ready   : write beat handshake
//   mem_addr          : word-aligned beat address
//   mem_wdata         : lane-aligned data, unstrobed bytes are zero
//   mem_wstrb         : byte write enables
//   misalign_err      : one-cycle pulse when a request is rejected
//   busy              : high while a store is in flight
//
// Handshake rule: a transfer happens on a rising edge where valid and ready
// are both high. A beat's addr/wdata/wstrb stay stable while it waits for
// mem_ready. The req_* inputs are sampled only on the accept edge.
// -----------------------------------------------------------------------------
module store_align_unit #(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [XLEN-1:0]     req_data,
   input  logic [2:0]          req_funct3,
   output logic                mem_valid,
   input  logic                mem_ready,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [XLEN-1:0]     mem_wdata,
   output logic [XLEN/8-1:0]   mem_wstrb,
   output logic                misalign_err,
   output logic                busy
);

   localparam int NB    = XLEN / 8;
   localparam int OFF_W = $clog2(NB);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BEAT0 = 2'd1,
      BEAT1 = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [XLEN-1:0]     wdata_q, wdata_d;
   logic [NB-1:0]       wstrb_q, wstrb_d;
   logic                err_q, err_d;

   // Request decode (combinational, used only on the accept edge)
   logic [OFF_W-1:0]    req_off;
   logic [ADDR_W-1:0]   req_base;
   logic [NB-1:0]       size_mask;
   logic [XLEN-1:0]     byte_keep;
   logic [XLEN-1:0]     src_data;
   logic [2*NB-1:0]     strb_wide;
   logic                crossing;
   logic                legal_op;
   logic                accept_ok;
   logic [XLEN-1:0]     beat0_data;

   assign req_off  = req_addr[OFF_W-1:0];
   assign req_base = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

   always_comb begin
      size_mask = '0;
      case (req_funct3[1:0])
         2'd0:    size_mask = NB'(1);
         2'd1:    size_mask = NB'(3);
         2'd2:    size_mask = NB'(15);
         default: size_mask = '1;
      endcase
   end

   // Expand the byte mask so source bytes above the store size are dropped.
   always_comb begin
      byte_keep = '0;
      for (int i = 0; i < NB; i++) begin
         byte_keep[8*i +: 8] = {8{size_mask[i]}};
      end
   end

   assign src_data = req_data & byte_keep;

   // Strobes over two consecutive words: the upper half marks bytes that
   // spill into the next word.
   assign strb_wide = {{NB{1'b0}}, size_mask} << req_off;
   assign crossing  = |strb_wide[2*NB-1:NB];
   assign legal_op  = !req_funct3[2] && !((req_funct3[1:0] == 2'd3) && (XLEN != 64));

`ifdef STORE_SPLIT_EN
   logic [2*XLEN-1:0]   data_wide;
   logic [ADDR_W-1:0]   hi_addr_q, hi_addr_d;
   logic [XLEN-1:0]     hi_wdata_q, hi_wdata_d;
   logic [NB-1:0]       hi_wstrb_q, hi_wstrb_d;
   logic                split_q, split_d;

   assign data_wide  = {{XLEN{1'b0}}, src_data} << {req_off, 3'b000};
   assign beat0_data = data_wide[XLEN-1:0];
   assign accept_ok  = legal_op;
`else
   assign beat0_data = src_data << {req_off, 3'b000};
   assign accept_ok  = legal_op && !crossing;
`endif

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      wstrb_d = wstrb_q;
      err_d   = 1'b0;
`ifdef STORE_SPLIT_EN
      hi_addr_d  = hi_addr_q;
      hi_wdata_d = hi_wdata_q;
      hi_wstrb_d = hi_wstrb_q;
      split_d    = split_q;
`endif
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               if (accept_ok) begin
                  addr_d  = req_base;
                  wdata_d = beat0_data;
                  wstrb_d = strb_wide[NB-1:0];
`ifdef STORE_SPLIT_EN
                  hi_addr_d  = req_base + ADDR_W'(NB);
                  hi_wdata_d = data_wide[2*XLEN-1:XLEN];
                  hi_wstrb_d = strb_wide[2*NB-1:NB];
                  split_d    = crossing;
`endif
                  state_d = BEAT0;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         BEAT0: begin
            if (mem_ready) begin
`ifdef STORE_SPLIT_EN
               if (split_q) begin
                  addr_d  = hi_addr_q;
                  wdata_d = hi_wdata_q;
                  wstrb_d = hi_wstrb_q;
                  state_d = BEAT1;
               end else begin
                  state_d = IDLE;
               end
`else
               state_d = IDLE;
`endif
            end
         end
         BEAT1: begin
            if (mem_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         wstrb_q <= wstrb_d;
         err_q   <= err_d;
      end
   end

`ifdef STORE_SPLIT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi_addr_q  <= '0;
         hi_wdata_q <= '0;
         hi_wstrb_q <= '0;
         split_q    <= 1'b0;
      end else begin
         hi_addr_q  <= hi_addr_d;
         hi_wdata_q <= hi_wdata_d;
         hi_wstrb_q <= hi_wstrb_d;
         split_q    <= split_d;
      end
   end
`endif

   assign req_ready    = (state_q == IDLE);
   assign busy         = (state_q != IDLE);
   assign mem_valid    = (state_q != IDLE);
   assign mem_addr     = addr_q;
   assign mem_wdata    = wdata_q;
   assign mem_wstrb    = wstrb_q;
   assign misalign_err = err_q;

endmodule
